// File: rtl/if_prefetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front-end: bus widths,
// reset PC, common constants and the redirect/fetch-state encodings.
package if_prefetch_unit_pkg;

  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_DATA_BUS_W = 32;

  localparam logic [INST_ADDR_BUS_W-1:0] RESET_PC_VAL = '0;
  localparam logic [31:0]                ZERO_WORD    = 32'h0000_0000;
  localparam logic                       ENABLE       = 1'b1;
  localparam logic                       DISABLE      = 1'b0;

  // Byte distance between consecutive word-aligned fetches.
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_ID,
    REDIR_EX
  } redirect_src_e;

  typedef enum logic {
    FETCH_RUN,
    FETCH_FLUSH
  } fetch_state_e;

  // EX resolves older instructions than ID, so it wins when both fire.
  function automatic redirect_src_e select_redirect(input logic ex_flag,
                                                    input logic id_flag);
    redirect_src_e sel;
    sel = REDIR_NONE;
    if (ex_flag) begin
      sel = REDIR_EX;
    end else if (id_flag) begin
      sel = REDIR_ID;
    end
    return sel;
  endfunction

endpackage

// File: rtl/if_prefetch_unit_sync_fifo.sv
// Synchronous FIFO with clear, occupancy count and a registered head entry;
// used as the prefetch queue between instruction memory and IF/ID.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign count   = cnt;
  assign rdata   = storage[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full queue can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: the head is only observed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (!rst && !clear && do_push) begin
      storage[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front-end: issues pipelined memory requests under a credit
// limit, queues returned instructions with their PCs and handles branch redirects.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = INST_ADDR_BUS_W,
  parameter int                    INST_WIDTH      = INST_DATA_BUS_W,
  parameter int                    FIFO_DEPTH      = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_rvalid_i,
  input  logic [INST_WIDTH-1:0] mem_rdata_i,
  input  logic                  ex_b_flag_i,
  input  logic [ADDR_WIDTH-1:0] ex_b_target_addr_i,
  input  logic                  id_b_flag_i,
  input  logic [ADDR_WIDTH-1:0] id_b_target_addr_i,
  input  logic                  stall_i,
  output logic                  inst_valid_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic                  stall_req_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int Q_W   = ADDR_WIDTH + INST_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [OUT_W-1:0]      outstanding;
  logic [OUT_W-1:0]      drop_cnt;
  fetch_state_e          state;

  redirect_src_e         redir_src;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redir_target;

  logic                  issue;
  logic                  accept;
  logic                  resp_live;
  logic [OUT_W-1:0]      outstanding_next;
  logic [OUT_W-1:0]      drop_next;

  logic                  q_push;
  logic                  q_pop;
  logic                  q_full;
  logic                  q_empty;
  logic [CNT_W-1:0]      q_count;
  logic [Q_W-1:0]        q_wdata;
  logic [Q_W-1:0]        q_rdata;

  always_comb begin
    redir_src    = select_redirect(ex_b_flag_i, id_b_flag_i);
    redirect     = (redir_src != REDIR_NONE);
    redir_target = '0;
    case (redir_src)
      REDIR_EX: redir_target = ex_b_target_addr_i & ALIGN_MASK;
      REDIR_ID: redir_target = id_b_target_addr_i & ALIGN_MASK;
      default:  redir_target = '0;
    endcase
  end

  // Counting queued plus in-flight entries reserves a slot for every live
  // response, so the queue can never be asked to accept more than it holds.
  assign issue = !rst && !redirect
              && (int'(outstanding) < MAX_OUTSTANDING)
              && ((int'(q_count) + int'(outstanding)) < FIFO_DEPTH);

  assign mem_req_o  = issue;
  assign mem_addr_o = fetch_pc;
  assign accept     = issue && mem_ready_i;

  assign resp_live = mem_rvalid_i && (state == FETCH_RUN);
  assign q_push    = resp_live && !redirect && (!q_full || q_pop);
  assign q_pop     = !q_empty && !stall_i && !redirect;
  assign q_wdata   = {resp_pc, mem_rdata_i};

  always_comb begin
    outstanding_next = outstanding + OUT_W'(accept) - OUT_W'(mem_rvalid_i);
    drop_next        = drop_cnt;
    if (redirect) begin
      // Every response still in flight predates the new target; the
      // outstanding count already covers any drops that were pending.
      if (mem_rvalid_i) begin
        drop_next = (outstanding != '0) ? outstanding - OUT_W'(1) : '0;
      end else begin
        drop_next = outstanding;
      end
    end else if (mem_rvalid_i && (drop_cnt != '0)) begin
      drop_next = drop_cnt - OUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      state       <= FETCH_RUN;
    end else begin
      outstanding <= outstanding_next;
      drop_cnt    <= drop_next;
      state       <= (drop_next != '0) ? FETCH_FLUSH : FETCH_RUN;
      if (redirect) begin
        fetch_pc <= redir_target;
        resp_pc  <= redir_target;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + PC_INC;
        end
        if (q_push) begin
          resp_pc <= resp_pc + PC_INC;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (Q_W),
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .clear (redirect),
    .wdata (q_wdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count),
    .rdata (q_rdata)
  );

  assign inst_valid_o = !q_empty;
  assign pc_o         = q_empty ? '0 : q_rdata[Q_W-1 -: ADDR_WIDTH];
  assign inst_o       = q_empty ? '0 : q_rdata[INST_WIDTH-1:0];
  assign stall_req_o  = q_empty;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: pipelined memory model with variable
// latency and an expected-PC scoreboard checked as instructions are consumed.
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        ex_b_flag_i;
  logic [31:0] ex_b_target_addr_i;
  logic        id_b_flag_i;
  logic [31:0] id_b_target_addr_i;
  logic        stall_i;
  logic        inst_valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        stall_req_o;

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;
  logic [31:0] exp_addr = '0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [31:0] addr;
    int          left;
  } pend_t;
  pend_t pend_q[$];

  always #5 clk = ~clk;

  if_prefetch_unit dut (
    .clk                (clk),
    .rst                (rst),
    .mem_req_o          (mem_req_o),
    .mem_addr_o         (mem_addr_o),
    .mem_ready_i        (mem_ready_i),
    .mem_rvalid_i       (mem_rvalid_i),
    .mem_rdata_i        (mem_rdata_i),
    .ex_b_flag_i        (ex_b_flag_i),
    .ex_b_target_addr_i (ex_b_target_addr_i),
    .id_b_flag_i        (id_b_flag_i),
    .id_b_target_addr_i (id_b_target_addr_i),
    .stall_i            (stall_i),
    .inst_valid_o       (inst_valid_o),
    .pc_o               (pc_o),
    .inst_o             (inst_o),
    .stall_req_o        (stall_req_o)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic st,
                               input logic ex, input logic [31:0] ext,
                               input logic id, input logic [31:0] idt);
    rst                = r;
    stall_i            = st;
    ex_b_flag_i        = ex;
    ex_b_target_addr_i = ext;
    id_b_flag_i        = id;
    id_b_target_addr_i = idt;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_restart(input logic [31:0] start);
    sb_q.delete();
    for (int i = 0; i < 64; i++) sb_q.push_back(start + 32'(4 * i));
    exp_addr = start;
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (!mem_req_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, mem_req_o, 1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!inst_valid_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, inst_valid_o, 1);
  endtask

  // Pipelined memory: fixed latency per request, in-order, flushed by reset.
  always @(posedge clk) begin
    pend_t p;
    if (rst) begin
      pend_q.delete();
      mem_rvalid_i <= 1'b0;
      mem_rdata_i  <= '0;
    end else begin
      foreach (pend_q[i]) pend_q[i].left = pend_q[i].left - 1;
      if (mem_req_o && mem_ready_i) begin
        checkOutput("mem_addr", mem_addr_o, exp_addr);
        exp_addr = exp_addr + 32'd4;
        p.addr = mem_addr_o;
        p.left = mem_lat - 1;
        pend_q.push_back(p);
      end
      if (pend_q.size() > 0 && pend_q[0].left <= 0) begin
        p = pend_q.pop_front();
        mem_rvalid_i <= 1'b1;
        mem_rdata_i  <= inst_of(p.addr);
      end else begin
        mem_rvalid_i <= 1'b0;
        mem_rdata_i  <= '0;
      end
    end
  end

  // Every instruction consumed must match the next expected PC and its data.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && inst_valid_o && !stall_i && !ex_b_flag_i && !id_b_flag_i) begin
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hFFFF_FFFF;
      checkOutput("head_pc", pc_o, e);
      checkOutput("head_inst", inst_o, inst_of(e));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    mem_ready_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    sb_restart(32'h0);

    @(negedge clk);
    checkOutput("rst_req", mem_req_o, 0);
    checkOutput("rst_valid", inst_valid_o, 0);
    checkOutput("rst_pc", pc_o, 0);
    checkOutput("rst_inst", inst_o, 0);
    checkOutput("rst_stall_req", stall_req_o, 1);

    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("c1_req", mem_req_o, 1);
    checkOutput("c1_addr", mem_addr_o, 32'h0);
    checkOutput("c1_valid", inst_valid_o, 0);
    checkOutput("c1_stall_req", stall_req_o, 1);
    tick(1);
    @(negedge clk);
    checkOutput("c2_addr", mem_addr_o, 32'h4);
    checkOutput("c2_valid", inst_valid_o, 0);
    checkOutput("c2_stall_req", stall_req_o, 1);
    tick(1);
    @(negedge clk);
    checkOutput("c3_valid", inst_valid_o, 1);
    checkOutput("c3_pc", pc_o, 32'h0);
    checkOutput("c3_inst", inst_o, inst_of(32'h0));
    checkOutput("c3_stall_req", stall_req_o, 0);
    checkOutput("c3_addr", mem_addr_o, 32'h8);
    tick(1);
    @(negedge clk);
    checkOutput("c4_req", mem_req_o, 1);
    checkOutput("c4_addr", mem_addr_o, 32'hC);
    tick(1);
    @(negedge clk);
    checkOutput("credit_full_req", mem_req_o, 0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      @(negedge clk);
      checkOutput("bp_pc_hold", pc_o, 32'h0);
      checkOutput("bp_req_low", mem_req_o, 0);
    end

    tick(1);
    stall_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("stream_valid", inst_valid_o, 1);
      tick(1);
    end

    mem_lat = 3;
    tick(8);
    for (int n = 0; n < 12 && !(pend_q.size() == 2 && !mem_rvalid_i); n++) tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("ex_redir_no_issue", mem_req_o, 0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    sb_restart(32'h100);
    @(negedge clk);
    checkOutput("ex_redir_empty", inst_valid_o, 0);
    checkOutput("ex_redir_stall_req", stall_req_o, 1);
    wait_req("ex_redir_req", 20);
    checkOutput("ex_redir_addr", mem_addr_o, 32'h100);
    wait_valid("ex_redir_valid", 20);
    checkOutput("ex_redir_pc", pc_o, 32'h100);
    tick(6);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300);
    @(negedge clk);
    checkOutput("dual_redir_no_issue", mem_req_o, 0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    sb_restart(32'h200);
    @(negedge clk);
    checkOutput("dual_redir_empty", inst_valid_o, 0);
    wait_req("dual_redir_req", 20);
    checkOutput("dual_redir_addr", mem_addr_o, 32'h200);
    wait_valid("dual_redir_valid", 20);
    checkOutput("dual_redir_pc", pc_o, 32'h200);
    tick(5);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h402);
    @(negedge clk);
    checkOutput("id_redir_no_issue", mem_req_o, 0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    sb_restart(32'h400);
    @(negedge clk);
    wait_req("id_redir_req", 20);
    checkOutput("id_redir_addr", mem_addr_o, 32'h400);
    wait_valid("id_redir_valid", 20);
    checkOutput("id_redir_pc", pc_o, 32'h400);
    tick(4);

    stall_i = 1'b1;
    tick(6);
    @(negedge clk);
    checkOutput("pre_reset_valid", inst_valid_o, 1);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("mid_rst_req", mem_req_o, 0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    sb_restart(32'h0);
    @(negedge clk);
    checkOutput("mid_rst_valid", inst_valid_o, 0);
    checkOutput("mid_rst_pc", pc_o, 32'h0);
    checkOutput("mid_rst_inst", inst_o, 32'h0);
    checkOutput("mid_rst_stall_req", stall_req_o, 1);
    checkOutput("mid_rst_req_after", mem_req_o, 1);
    checkOutput("mid_rst_addr", mem_addr_o, 32'h0);
    wait_valid("mid_rst_first_valid", 20);
    checkOutput("mid_rst_first_pc", pc_o, 32'h0);
    tick(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
